// File: rtl/intr_aggregator.sv
// intr_aggregator: latches rising edges of interrupt sources, masks them, and
// drives one aggregated interrupt that is either a level (OR of the masked
// status) or a stream of fixed-width pulses produced by a small FSM.
// Optional build macro INTR_AGG_SWSET_EN adds a software-set port pair
// (i_swset_vld / i_swset) that sets raw bits the same way a source edge does.
module intr_aggregator #(
  parameter int                N_SRC      = 14,
  parameter int                PULSE_W_BW = 8,
  parameter logic [N_SRC-1:0]  NMI_MASK   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_SRC-1:0]      i_src,
  input  logic [N_SRC-1:0]      i_msk,
  input  logic                  i_clr_vld,
  input  logic [N_SRC-1:0]      i_clr,
  input  logic                  i_type,
  input  logic [PULSE_W_BW-1:0] i_width,
`ifdef INTR_AGG_SWSET_EN
  input  logic                  i_swset_vld,
  input  logic [N_SRC-1:0]      i_swset,
`endif
  output logic [N_SRC-1:0]      o_raw,
  output logic [N_SRC-1:0]      o_stat,
  output logic                  o_intr,
  output logic                  o_busy
);

  typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

  localparam logic [PULSE_W_BW-1:0] CNT_ONE = {{(PULSE_W_BW-1){1'b0}}, 1'b1};

  state_t                state, state_nxt;
  logic [N_SRC-1:0]      src_q, raw, stat_q;
  logic [N_SRC-1:0]      rise, set_bits, clr_bits;
  logic [PULSE_W_BW-1:0] cnt, cnt_nxt, width_q, width_nxt;
  logic                  pend, pend_nxt;
  logic                  level_q;
  logic                  evt;

  // A width of zero still yields a one-cycle pulse.
  function automatic logic [PULSE_W_BW-1:0] pulse_len(input logic [PULSE_W_BW-1:0] w);
    return (w == '0) ? CNT_ONE : w;
  endfunction

  // Edge detect and the set/clear vectors feeding the raw status register.
  always_comb begin
    rise     = i_src & ~src_q;
    clr_bits = i_clr_vld ? i_clr : '0;
`ifdef INTR_AGG_SWSET_EN
    set_bits = rise | (i_swset_vld ? i_swset : '0);
`else
    set_bits = rise;
`endif
  end

  assign o_raw  = raw;
  assign o_stat = raw & (i_msk | NMI_MASK);
  // Any masked bit that was not set last cycle counts as a new event,
  // including a raw bit that has just been unmasked.
  assign evt    = |(o_stat & ~stat_q);

  // Source history, raw status (set beats clear) and previous masked status.
  always_ff @(posedge clk) begin
    if (rst) begin
      src_q  <= '0;
      raw    <= '0;
      stat_q <= '0;
    end else begin
      src_q  <= i_src;
      raw    <= (raw & ~clr_bits) | set_bits;
      stat_q <= o_stat;
    end
  end

  // Level-mode output: registered OR of masked status, only while IDLE in level mode.
  always_ff @(posedge clk) begin
    if (rst) level_q <= 1'b0;
    else     level_q <= (state == IDLE) && !i_type && (|o_stat);
  end

  // Pulse FSM state, counter, pending flag and the width sampled in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      pend    <= 1'b0;
      width_q <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      pend    <= pend_nxt;
      width_q <= width_nxt;
    end
  end

  // Next-state logic; the counter only counts down to one so it never wraps.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pend_nxt  = pend;
    width_nxt = width_q;
    case (state)
      IDLE: begin
        pend_nxt  = 1'b0;
        width_nxt = i_width;
        if (i_type && evt) begin
          state_nxt = PULSE;
          cnt_nxt   = pulse_len(i_width);
        end
      end
      PULSE: begin
        if (evt) pend_nxt = 1'b1;
        if (cnt <= CNT_ONE) state_nxt = GAP;
        else                cnt_nxt   = cnt - CNT_ONE;
      end
      GAP: begin
        if (pend || evt) begin
          state_nxt = PULSE;
          cnt_nxt   = pulse_len(width_q);
          pend_nxt  = 1'b0;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign o_intr = (state == PULSE) || ((state == IDLE) && level_q);
  assign o_busy = (state != IDLE);

endmodule
